d_mem_be: RTL and testbench
===========================

D_MEM_BE -- requirements
Module: d_mem_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width; only 32 is supported, and other values SHALL fail elaboration.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words; must be a power of 2, minimum 4.
REQ-004 SHALL have parameter READ_LATENCY, default 1, cycles from request acceptance to response; legal range 1..3.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  in  1  request present.
REQ-008 SHALL have port req_ready  out  1  request accepted this cycle when high together with req_valid.
REQ-009 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-010 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-011 SHALL have port req_signed  in  1  sign-extend a load; ignored for stores and word loads.
REQ-012 SHALL have port adr  in  ADDR_WIDTH  byte address.
REQ-013 SHALL have port data_in  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-014 SHALL have port rsp_valid  out  1  load response present.
REQ-015 SHALL have port rsp_ready  in  1  consumer accepts the response.
REQ-016 SHALL have port data_out  out  DATA_WIDTH  load data, right-aligned and extended.
REQ-017 SHALL have port misalign_err  out  1  qualifies rsp_valid; the request was misaligned or reserved.

Function
REQ-018 SHALL compute stall = rsp_valid && !rsp_ready and drive req_ready = !stall.
REQ-019 SHALL hold every pipeline stage, data_out and misalign_err stable while stall is high.
REQ-020 SHALL use word index adr[log2(DEPTH_WORDS)+1:2] and byte offset adr[1:0]; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-021 SHALL write an accepted, aligned store at that accepting edge, using byte lanes: byte -> lane adr[1:0]; half -> lanes adr[1]*2 and adr[1]*2+1; word -> all 4 lanes. Unselected lanes are unchanged.
REQ-022 SHALL produce no response for stores.
REQ-023 SHALL read memory for an accepted load at the accepting edge and present rsp_valid exactly READ_LATENCY cycles later, absent stall.
REQ-024 SHALL let a load accepted in the cycle after a store to the same word return the post-store data.
REQ-025 SHALL shift the selected byte or half to bit 0 on a load, then zero-extend, or sign-extend when req_signed=1.
REQ-026 SHALL treat as misaligned: half with adr[0]=1, word with adr[1:0]!=0, and req_size=11.
REQ-027 SHALL drop a misaligned store with no memory change.
REQ-028 SHALL answer a misaligned load with rsp_valid=1, misalign_err=1 and data_out=0.
REQ-029 SHALL support back-to-back accepted requests every cycle with no bubbles while rsp_ready=1.
REQ-030 SHALL order responses to match load acceptance order.

Reset
REQ-031 SHALL, on rst_n low, immediately clear all pipeline valid bits and drive rsp_valid=0, data_out=0 and misalign_err=0; req_ready SHALL then be 1.
REQ-032 SHALL discard in-flight loads when reset occurs mid-operation, with no response after reset release.
REQ-033 SHALL leave memory contents unaffected by reset.

Structure
REQ-034 SHALL define size encodings (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD) and lane count 4 in shared package d_mem_pkg.
REQ-035 SHALL instantiate sub-module d_mem_lane 4 times: one byte-wide, DEPTH_WORDS-deep, single-port synchronous RAM per lane (clk, we, addr, din, dout).

Verification
REQ-036 Store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid after READ_LATENCY cycles, data_out=0xDEADBEEF, misalign_err=0.
REQ-037 Store byte 0x80 @0x13, then load signed byte @0x13 -> 0xFFFFFF80; unsigned byte -> 0x00000080; word @0x10 -> 0x80ADBEEF.
REQ-038 Load half @0x11 -> misalign_err=1, data_out=0; store word @0x12 leaves word @0x10 unchanged.
REQ-039 Issue 4 back-to-back loads with rsp_ready=0 for 3 cycles -> req_ready=0 during stall, no lost or duplicated response, order preserved.
REQ-040 Store @(DEPTH_WORDS*4 + 0x4) -> readable @0x4 (wrap).
REQ-041 Assert rst_n low with 2 loads in flight -> rsp_valid=0 immediately and stays 0 after release; memory data is retained.

Source files
------------

// File: rtl/d_mem_pkg.sv
// Shared definitions for the byte-enabled data memory: size encodings, lane count,
// and helpers for lane selection, store replication and load formatting.
package d_mem_pkg;

  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      SZ_RSVD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'(4'b0001 << off);
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data so every candidate lane sees its byte.
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sgn);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (sz)
      SZ_BYTE: return {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/d_mem_lane.sv
// One byte lane of the data memory: single-port synchronous RAM, read-first.
module d_mem_lane #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               din,
  output logic [7:0]               dout
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/d_mem_be.sv
// Byte-enabled data memory with valid/ready request and response, fixed read latency,
// sign/zero-extending sub-word loads and misalignment reporting.
module d_mem_be
  import d_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  misalign_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  generate
    if (DATA_WIDTH != 32) begin : g_bad_dw
      $error("d_mem_be: DATA_WIDTH must be 32");
    end
    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("d_mem_be: DEPTH_WORDS must be a power of 2 and at least 4");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_lat
      $error("d_mem_be: READ_LATENCY must be 1..3");
    end
    if (ADDR_WIDTH < IDX_W + 2) begin : g_bad_aw
      $error("d_mem_be: ADDR_WIDTH too small for DEPTH_WORDS");
    end
    // Upper address bits alias onto the array.
    if (ADDR_WIDTH > IDX_W + 2) begin : g_adr_hi
      logic unused_adr_hi;
      assign unused_adr_hi = ^adr[ADDR_WIDTH-1:IDX_W+2];
    end
  endgenerate

  logic             stall;
  logic             accept;
  logic             req_err;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] rd_idx_q;
  logic [IDX_W-1:0] ram_addr;
  logic [LANES-1:0] lane_we;
  logic [31:0]      wdata;
  logic [31:0]      rdata;

  logic             s1_valid;
  logic             s1_err;
  logic [1:0]       s1_size;
  logic [1:0]       s1_off;
  logic             s1_sgn;
  logic [31:0]      s1_data;

  assign stall     = rsp_valid & ~rsp_ready;
  assign req_ready = ~stall;
  assign accept    = req_valid & ~stall;
  assign req_idx   = adr[IDX_W+1:2];
  assign req_err   = is_misaligned(req_size, adr[1:0]);
  assign wdata     = store_data(req_size, 32'(data_in));
  assign lane_we   = (accept & req_we & ~req_err) ? lane_mask(req_size, adr[1:0]) : '0;
  // While not accepting, re-read the last load's word so RAM output holds across a stall.
  assign ram_addr  = accept ? req_idx : rd_idx_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    d_mem_lane #(.DEPTH(DEPTH_WORDS)) u_lane (
      .clk  (clk),
      .we   (lane_we[i]),
      .addr (ram_addr),
      .din  (wdata[8*i +: 8]),
      .dout (rdata[8*i +: 8])
    );
  end

  // First stage: request attributes aligned with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_size  <= 2'b00;
      s1_off   <= 2'b00;
      s1_sgn   <= 1'b0;
      rd_idx_q <= '0;
    end else if (!stall) begin
      s1_valid <= accept & ~req_we;
      s1_err   <= req_err;
      s1_size  <= req_size;
      s1_off   <= adr[1:0];
      s1_sgn   <= req_signed;
      if (accept && !req_we) begin
        rd_idx_q <= req_idx;
      end
    end
  end

  assign s1_data = s1_err ? 32'h0 : fmt_load(rdata, s1_size, s1_off, s1_sgn);

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign rsp_valid    = s1_valid;
      assign misalign_err = s1_valid & s1_err;
      assign data_out     = s1_valid ? DATA_WIDTH'(s1_data) : '0;
    end else begin : g_latn
      localparam int unsigned NS = READ_LATENCY - 1;
      logic [NS-1:0] v_q;
      logic [NS-1:0] e_q;
      logic [31:0]   d_q [NS];

      // Extra delay stages carry already-formatted, zero-when-idle data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= '0;
          e_q <= '0;
          for (int i = 0; i < int'(NS); i++) d_q[i] <= 32'h0;
        end else if (!stall) begin
          v_q[0] <= s1_valid;
          e_q[0] <= s1_valid & s1_err;
          d_q[0] <= s1_valid ? s1_data : 32'h0;
          for (int i = 1; i < int'(NS); i++) begin
            v_q[i] <= v_q[i-1];
            e_q[i] <= e_q[i-1];
            d_q[i] <= d_q[i-1];
          end
        end
      end

      assign rsp_valid    = v_q[NS-1];
      assign misalign_err = e_q[NS-1];
      assign data_out     = DATA_WIDTH'(d_q[NS-1]);
    end
  endgenerate

endmodule

// File: tb/tb_d_mem_be.sv
// Randomized scoreboard bench for d_mem_be against a byte-array reference memory.
module tb_d_mem_be;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 1;
  localparam int unsigned BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] adr;
  logic [31:0] data_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] data_out;
  logic        misalign_err;

  always #5 clk = ~clk;

  d_mem_be #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .DEPTH_WORDS  (DEPTH),
    .READ_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .adr          (adr),
    .data_in      (data_in),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .data_out     (data_out),
    .misalign_err (misalign_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc_cyc;
    int          stall_at;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mb [BYTES];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         stall_total = 0;
  bit         prev_stall = 1'b0;
  bit         rand_mode = 1'b0;

  function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic void model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int unsigned ba;
    ba = a % BYTES;
    for (int k = 0; k < int'(nbytes(sz)); k++) mb[ba + k] = 8'((d >> (8 * k)) & 32'hFF);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sgn, input logic [31:0] a);
    int unsigned ba, n;
    logic [31:0] v;
    if (misal(sz, a)) return 32'h0;
    ba = a % BYTES;
    n  = nbytes(sz);
    v  = 32'h0;
    for (int k = 0; k < int'(n); k++) v = v | (32'(mb[ba + k]) << (8 * k));
    if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: model update on acceptance, response check against queue head.
  initial begin
    exp_t e;
    bit   stall_now;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got data=%h err=%b, required no response", data_out, misalign_err);
        end else begin
          e = exp_q[0];
          chk("rsp_data", data_out, e.data);
          chk("rsp_err", 32'(misalign_err), 32'(e.err));
          if (!prev_stall)
            chk("rsp_latency", 32'(cyc), 32'(e.acc_cyc + int'(LAT) + (stall_total - e.stall_at)));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      stall_now = rsp_valid && !rsp_ready;
      chk("req_ready", 32'(req_ready), 32'(!stall_now));
      if (stall_now) stall_total++;
      prev_stall = stall_now;
      if (req_valid && req_ready) begin
        if (!req_we) begin
          e.data     = model_load(req_size, req_signed, adr);
          e.err      = misal(req_size, adr);
          e.acc_cyc  = cyc;
          e.stall_at = stall_total;
          exp_q.push_back(e);
        end else if (!misal(req_size, adr)) begin
          model_store(req_size, adr, data_in);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] d);
    int guard;
    guard      = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sgn;
    adr        = a;
    data_in    = d;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      guard++;
      if (guard > 100) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got req_ready=0 for 100 cycles, required 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    adr        = 32'h0;
    data_in    = 32'h0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_misalign", 32'(misalign_err), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < int'(DEPTH); i++) issue(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom());

    // Basic word, signed/unsigned byte, misaligned and reserved cases.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h80);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h16, 32'hA5F0C3E1);
    issue(1'b0, 2'd1, 1'b1, 32'h16, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h16, 32'h0);
    drain();

    // Four back-to-back loads with a three-cycle consumer stall.
    s0 = stall_total;
    fork
      begin
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h17, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h1C, 32'h0);
      end
      begin
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    drain();
    chk("stall_cycles", 32'(stall_total - s0), 32'd3);

    // Address wrap.
    issue(1'b1, 2'd2, 1'b0, 32'(BYTES + 4), 32'hCAFEF00D);
    issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    drain();

    // Reset with loads in flight.
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_data_out", data_out, 32'h0);
    chk("midrst_misalign", 32'(misalign_err), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    drain();

    // Randomized mixed traffic with random consumer back-pressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom());
      end
    end
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
